// File: rtl/hdr_word_strobe_gen_pkg.sv
// Shared state encodings and helpers for the header-word strobe generator.
package hdr_parse_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_MOD_HDRS = 3'b001;
    localparam state_t ST_HDR      = 3'b010;
    localparam state_t ST_WAIT_EOP = 3'b100;

    localparam int STAT_WIDTH = 32;

    // Ceiling log2, used to size the word index.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/hdr_word_strobe_gen_if.sv
// Ctrl/data bus as seen by the preprocess chain; the generator only monitors it.
interface hdr_word_strobe_gen_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic [CTRL_WIDTH-1:0] in_ctrl;
    logic                  in_wr;

    modport master (output in_data, output in_ctrl, output in_wr);
    modport slave  (input  in_data, input  in_ctrl, input  in_wr);
endinterface

// File: rtl/hdr_word_strobe_gen.sv
// Header-word strobe generator: one-hot strobe per header word, hdr_done/short_pkt pulses.
// Optional packet statistics counters are built when PKT_STATS_EN is defined.
module hdr_word_strobe_gen
    import hdr_parse_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int NUM_HDR_WORDS = 5,
    localparam int IDX_WIDTH    = log2(NUM_HDR_WORDS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    hdr_word_strobe_gen_if.slave     bus,
    output logic [NUM_HDR_WORDS-1:0] word_strobe,
    output logic [IDX_WIDTH-1:0]     word_idx,
    output logic                     in_pkt_body,
    output logic                     hdr_done,
    output logic                     short_pkt
`ifdef PKT_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]    pkt_cnt,
    output logic [STAT_WIDTH-1:0]    short_cnt
`endif
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_HDR_WORDS - 1);

    logic [DATA_WIDTH-1:0] data_unused;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  is_ctrl;

    assign data_unused = bus.in_data;
    assign ctrl        = bus.in_ctrl;
    assign wr          = bus.in_wr;
    assign is_ctrl     = |ctrl;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] word_idx_q, word_idx_d;
    logic                 synced_q, synced_d;
    logic                 in_pkt_body_q, in_pkt_body_d;
    logic                 hdr_done_q, hdr_done_d;
    logic                 short_pkt_q, short_pkt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_MOD_HDRS;
            word_idx_q    <= '0;
            synced_q      <= 1'b0;
            in_pkt_body_q <= 1'b0;
            hdr_done_q    <= 1'b0;
            short_pkt_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            synced_q      <= synced_d;
            in_pkt_body_q <= in_pkt_body_d;
            hdr_done_q    <= hdr_done_d;
            short_pkt_q   <= short_pkt_d;
        end
    end

    // synced_q stays low after reset until a ctrl word is seen, so the tail of a
    // packet interrupted by reset is never mistaken for a new header.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        synced_d   = synced_q;
        case (state_q)
            ST_MOD_HDRS: begin
                if (wr) begin
                    if (is_ctrl) begin
                        synced_d = 1'b1;
                    end else if (synced_q) begin
                        word_idx_d = IDX_WIDTH'(1);
                        state_d    = (NUM_HDR_WORDS == 1) ? ST_WAIT_EOP : ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (wr) begin
                    if (is_ctrl) begin
                        state_d    = ST_MOD_HDRS;
                        word_idx_d = '0;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        if (word_idx_q == LAST_IDX) state_d = ST_WAIT_EOP;
                    end
                end
            end
            ST_WAIT_EOP: begin
                if (wr && is_ctrl) begin
                    state_d    = ST_MOD_HDRS;
                    word_idx_d = '0;
                end
            end
            default: begin
                state_d    = ST_MOD_HDRS;
                word_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        word_strobe   = '0;
        hdr_done_d    = 1'b0;
        short_pkt_d   = 1'b0;
        in_pkt_body_d = (state_d != ST_MOD_HDRS);
        if (wr && !reset) begin
            case (state_q)
                ST_MOD_HDRS: begin
                    if (!is_ctrl && synced_q) begin
                        word_strobe[0] = 1'b1;
                        hdr_done_d     = (NUM_HDR_WORDS == 1);
                    end
                end
                ST_HDR: begin
                    for (int i = 0; i < NUM_HDR_WORDS; i++)
                        if (word_idx_q == IDX_WIDTH'(i)) word_strobe[i] = 1'b1;
                    hdr_done_d  = (word_idx_q == LAST_IDX);
                    short_pkt_d = is_ctrl && (word_idx_q != LAST_IDX);
                end
                default: ;
            endcase
        end
    end

    assign word_idx    = word_idx_q;
    assign in_pkt_body = in_pkt_body_q;
    assign hdr_done    = hdr_done_q;
    assign short_pkt   = short_pkt_q;

`ifdef PKT_STATS_EN
    logic [STAT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [STAT_WIDTH-1:0] short_cnt_q, short_cnt_d;
    logic                  eop_seen;

    assign eop_seen = wr && is_ctrl && (state_q != ST_MOD_HDRS);

    // Both counters saturate rather than wrap.
    always_comb begin
        pkt_cnt_d   = pkt_cnt_q;
        short_cnt_d = short_cnt_q;
        if (eop_seen && (pkt_cnt_q != '1))      pkt_cnt_d   = pkt_cnt_q + 1'b1;
        if (short_pkt_d && (short_cnt_q != '1)) short_cnt_d = short_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q   <= '0;
            short_cnt_q <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            short_cnt_q <= short_cnt_d;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign short_cnt = short_cnt_q;
`endif

endmodule

// File: tb/tb_hdr_word_strobe_gen.sv
// Self-checking bench for hdr_word_strobe_gen (NUM_HDR_WORDS=5); stats checks when PKT_STATS_EN.
module tb_hdr_word_strobe_gen;

    localparam int N  = 5;
    localparam int IW = 3;
    localparam logic [7:0] MOD_HDR = 8'hFF;
    localparam logic [7:0] EOP     = 8'h01;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hdr_word_strobe_gen_if bus ();

    logic [N-1:0]  word_strobe;
    logic [IW-1:0] word_idx;
    logic          in_pkt_body, hdr_done, short_pkt;
`ifdef PKT_STATS_EN
    logic [31:0]   pkt_cnt, short_cnt;
`endif

    hdr_word_strobe_gen #(.DATA_WIDTH(64), .NUM_HDR_WORDS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .word_strobe (word_strobe),
        .word_idx    (word_idx),
        .in_pkt_body (in_pkt_body),
        .hdr_done    (hdr_done),
        .short_pkt   (short_pkt)
`ifdef PKT_STATS_EN
        ,
        .pkt_cnt     (pkt_cnt),
        .short_cnt   (short_cnt)
`endif
    );

    typedef struct {
        logic [N-1:0]  strobe;
        logic          hd;
        logic          sp;
        logic          body;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    logic [N-1:0]  o_strobe;
    logic          o_hd, o_sp, o_body;
    logic [IW-1:0] o_idx;

    // One bus cycle: drive at negedge, sample the strobe before the edge, flops after it.
    task automatic step(input logic [7:0] ctrl, input logic wr);
        @(negedge clk);
        bus.in_ctrl = ctrl;
        bus.in_wr   = wr;
        bus.in_data = {$urandom, $urandom};
        #2 o_strobe = word_strobe;
        @(posedge clk);
        #1;
        o_hd   = hdr_done;
        o_sp   = short_pkt;
        o_body = in_pkt_body;
        o_idx  = word_idx;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(8'h00, 1'b0);
        step(8'h00, 1'b1);
        checks++;
        if ({o_strobe, o_hd, o_sp, o_body, o_idx} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {o_strobe, o_hd, o_sp, o_body, o_idx}, 11'b0);
        end
`ifdef PKT_STATS_EN
        checks++;
        if ({pkt_cnt, short_cnt} !== 64'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%h exp=0", {pkt_cnt, short_cnt});
        end
`endif
        reset = 1'b0;
        // Without a preceding ctrl word, ctrl==0 words are not header words.
        for (int i = 0; i < 2; i++) begin
            step(8'h00, 1'b1);
            checks++;
            if ({o_strobe, o_hd, o_sp, o_body, o_idx} !== '0) begin
                failures++;
                $display("FAIL unsynced_w%0d got=%b exp=%b", i, {o_strobe, o_hd, o_sp, o_body, o_idx}, 11'b0);
            end
        end
    endtask

    task automatic test_pkt(input string name, input int n_mod, input int eop, input int gap_max);
        exp_t e, got;
        logic          cur_body;
        logic [IW-1:0] cur_idx;
        cur_body = 1'b0;
        cur_idx  = '0;
        for (int m = 0; m < n_mod; m++) begin
            e = '{strobe: '0, hd: 1'b0, sp: 1'b0, body: 1'b0, idx: '0};
            sb.push_back(e);
            step(MOD_HDR, 1'b1);
            got = sb.pop_front();
            checks++;
            if ({o_strobe, o_hd, o_sp, o_body, o_idx} !== {got.strobe, got.hd, got.sp, got.body, got.idx}) begin
                failures++;
                $display("FAIL %s mod%0d got=%b exp=%b", name, m,
                         {o_strobe, o_hd, o_sp, o_body, o_idx}, {got.strobe, got.hd, got.sp, got.body, got.idx});
            end
        end
        for (int k = 0; k <= eop; k++) begin
            if (gap_max > 0) begin
                for (int g = $urandom_range(gap_max, 1); g > 0; g--) begin
                    step(8'h00, 1'b0);
                    checks++;
                    if ({o_strobe, o_hd, o_sp, o_body, o_idx} !== {{N{1'b0}}, 2'b00, cur_body, cur_idx}) begin
                        failures++;
                        $display("FAIL %s gap_w%0d got=%b exp=%b", name, k,
                                 {o_strobe, o_hd, o_sp, o_body, o_idx}, {{N{1'b0}}, 2'b00, cur_body, cur_idx});
                    end
                end
            end
            e.strobe = (k < N) ? N'(1 << k) : '0;
            e.hd     = (k == N - 1);
            e.sp     = (k == eop) && (eop < N - 1);
            e.body   = (k != eop);
            e.idx    = (k == eop) ? '0 : IW'((k + 1 < N) ? k + 1 : N);
            sb.push_back(e);
            step((k == eop) ? EOP : 8'h00, 1'b1);
            got = sb.pop_front();
            checks++;
            if ({o_strobe, o_hd, o_sp, o_body, o_idx} !== {got.strobe, got.hd, got.sp, got.body, got.idx}) begin
                failures++;
                $display("FAIL %s w%0d got=%b exp=%b", name, k,
                         {o_strobe, o_hd, o_sp, o_body, o_idx}, {got.strobe, got.hd, got.sp, got.body, got.idx});
            end
            cur_body = got.body;
            cur_idx  = got.idx;
        end
    endtask

    task automatic test_reset_mid_pkt();
        exp_t e, got;
        logic [7:0] ctrl;
        for (int k = -1; k <= 7; k++) begin
            // k=-1 is the module header, reset lands on body word 2, EOP on word 7.
            ctrl = (k < 0) ? MOD_HDR : ((k == 7) ? EOP : 8'h00);
            if (k == 0 || k == 1)
                e = '{strobe: N'(1 << k), hd: 1'b0, sp: 1'b0, body: 1'b1, idx: IW'(k + 1)};
            else
                e = '{strobe: '0, hd: 1'b0, sp: 1'b0, body: 1'b0, idx: '0};
            sb.push_back(e);
            reset = (k == 2);
            step(ctrl, 1'b1);
            got = sb.pop_front();
            checks++;
            if ({o_strobe, o_hd, o_sp, o_body, o_idx} !== {got.strobe, got.hd, got.sp, got.body, got.idx}) begin
                failures++;
                $display("FAIL rst_mid w%0d got=%b exp=%b", k,
                         {o_strobe, o_hd, o_sp, o_body, o_idx}, {got.strobe, got.hd, got.sp, got.body, got.idx});
            end
        end
        reset = 1'b0;
        test_pkt("after_rst", 1, 7, 0);
    endtask

    task automatic test_back_to_back();
        test_pkt("b2b_a", 1, 5, 0);
        test_pkt("b2b_b", 2, 1, 0);
        test_pkt("b2b_c", 0, 4, 0);
        test_pkt("b2b_d", 1, 3, 0);
        step(8'h00, 1'b0);
    endtask

`ifdef PKT_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        step(8'h00, 1'b0);
        reset = 1'b0;
        test_pkt("st_g0", 1, 7, 0);
        test_pkt("st_s0", 1, 2, 0);
        test_pkt("st_g1", 1, 4, 0);
        test_pkt("st_s1", 1, 1, 0);
        test_pkt("st_g2", 1, 5, 0);
        step(8'h00, 1'b0);
        checks++;
        if (pkt_cnt !== 32'd5) begin
            failures++;
            $display("FAIL pkt_cnt got=%0d exp=5", pkt_cnt);
        end
        checks++;
        if (short_cnt !== 32'd2) begin
            failures++;
            $display("FAIL short_cnt got=%0d exp=2", short_cnt);
        end
        force dut.pkt_cnt_q = 32'hFFFF_FFFE;
        force dut.short_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.pkt_cnt_q;
        release dut.short_cnt_q;
        for (int i = 0; i < 3; i++) test_pkt("st_sat", 1, 1, 0);
        step(8'h00, 1'b0);
        checks++;
        if (pkt_cnt !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL pkt_cnt_sat got=%h exp=ffffffff", pkt_cnt);
        end
        checks++;
        if (short_cnt !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL short_cnt_sat got=%h exp=ffffffff", short_cnt);
        end
    endtask
`endif

    initial begin
        bus.in_data = '0;
        bus.in_ctrl = '0;
        bus.in_wr   = 1'b0;
        test_reset();
        test_pkt("full", 1, 7, 0);
        step(8'h00, 1'b0);
        test_pkt("short", 1, 2, 0);
        test_pkt("after_short", 1, 7, 0);
        test_pkt("eop_last", 1, 4, 0);
        test_pkt("gaps", 1, 7, 3);
        test_reset_mid_pkt();
        test_back_to_back();
`ifdef PKT_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
